key_expansion: RTL and testbench

AES-128 key schedule engine. On a start pulse it captures a 128-bit cipher key and derives the ten following round keys, one per clock, into an 11-entry on-chip key store. Once expansion completes, the round controller selects any stored key by round index. The selected key drives the round-key input of the add-round-key stage directly, and that stage sits immediately downstream of this block.

---
 rtl/key_expansion.sv | 114 +++++++++++
 tb/tb_key_expansion.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// key_expansion: AES-128 key schedule with an 11-entry round key store.

// aes_sbox: combinational AES forward S-box lookup.
module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);
    localparam logic [7:0] sbox_table [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    assign sub_val = sbox_table[byte_val];
endmodule

module key_expansion (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [0:3][31:0] cipher_key,
    input  logic [3:0]       round_sel,
    output logic [0:3][31:0] round_key,
    output logic             busy,
    output logic             keys_ready
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t          state;
    logic [0:3][31:0] key_mem [11];
    logic [3:0]      rnd;
    logic [7:0]      rcon;
    logic [0:3][31:0] prev;
    logic [0:3][31:0] next_key;
    logic [31:0]     rot;
    logic [31:0]     sub;
    logic [31:0]     t;
    logic [3:0]      prev_idx;

    assign prev_idx = rnd - 4'd1;
    assign prev     = key_mem[prev_idx];
    assign rot      = {prev[3][23:0], prev[3][31:24]};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_sbox
            aes_sbox u_sbox (.byte_val(rot[8*i +: 8]), .sub_val(sub[8*i +: 8]));
        end
    endgenerate

    assign t = sub ^ {rcon, 24'h0};

    // Next round key: each word chains off the one just derived.
    always_comb begin
        next_key[0] = prev[0] ^ t;
        next_key[1] = prev[1] ^ next_key[0];
        next_key[2] = prev[2] ^ next_key[1];
        next_key[3] = prev[3] ^ next_key[2];
    end

    // Selected key is only visible once the whole schedule is valid.
    always_comb begin
        round_key = '0;
        if (keys_ready && round_sel <= 4'd10) round_key = key_mem[round_sel];
    end

    // Control FSM, key store, round counter and rcon sequence.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            rnd        <= 4'd0;
            rcon       <= 8'h01;
            for (int k = 0; k < 11; k++) key_mem[k] <= '0;
        end else begin
            case (state)
                EXPAND: begin
                    key_mem[rnd] <= next_key;
                    rnd          <= rnd + 4'd1;
                    rcon         <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (rnd == 4'd10) begin
                        state      <= READY;
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                    end
                end
                IDLE, READY: begin
                    if (start) begin
                        key_mem[0] <= cipher_key;
                        rcon       <= 8'h01;
                        rnd        <= 4'd1;
                        state      <= EXPAND;
                        busy       <= 1'b1;
                        keys_ready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: scoreboard bench for the AES-128 key schedule engine.
module tb_key_expansion;
    logic             clk = 1'b0;
    logic             n_rst;
    logic             start;
    logic [0:3][31:0] cipher_key;
    logic [3:0]       round_sel;
    logic [0:3][31:0] round_key;
    logic             busy;
    logic             keys_ready;

    int checks = 0;
    int fails  = 0;

    logic [127:0] sb_q [$];
    logic [3:0]   sel_q [$];
    logic [7:0]   sbox_ref [256];
    logic [127:0] model_keys [11];

    localparam logic [127:0] KEY_A1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] A1_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] A1_R2  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    localparam logic [127:0] A1_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] Z_R1   = 128'h62636363_62636363_62636363_62636363;
    localparam logic [127:0] Z_R10  = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    key_expansion dut (
        .clk(clk), .n_rst(n_rst), .start(start), .cipher_key(cipher_key),
        .round_sel(round_sel), .round_key(round_key), .busy(busy), .keys_ready(keys_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    // Key schedule in the 44-word formulation.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        for (int k = 0; k < 4; k++) w[k] = key[127 - 32*k -: 32];
        for (int k = 4; k < 44; k++) begin
            temp = w[k-1];
            if (k % 4 == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[k] = w[k-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: compares round_key against the scoreboard once per cycle away from the edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            logic [127:0] e;
            logic [3:0]   s;
            e = sb_q.pop_front();
            s = sel_q.pop_front();
            checks++;
            if (round_key !== e) begin
                fails++;
                $display("FAIL round_key sel=%0d: got %h expected %h", s, round_key, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [3:0] sel, input logic [127:0] exp);
        round_sel = sel;
        sb_q.push_back(exp);
        sel_q.push_back(sel);
        tick();
    endtask

    task automatic probe_all_model();
        for (int s = 0; s < 16; s++) probe(4'(s), s <= 10 ? model_keys[s] : 128'h0);
        for (int k = 0; k < 6; k++) begin
            int s = $urandom_range(0, 15);
            probe(4'(s), s <= 10 ? model_keys[s] : 128'h0);
        end
    endtask

    // Pulses start and measures busy; optionally re-pulses start mid-expansion with key2.
    task automatic run_expand(input logic [127:0] key, input int restart_at, input logic [127:0] key2);
        int n = 0;
        logic ready_early = 1'b0;
        cipher_key = key;
        start = 1'b1;
        tick();
        start = 1'b0;
        cipher_key = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 20; c++) begin
            if (!busy) break;
            if (keys_ready) ready_early = 1'b1;
            n++;
            if (n == restart_at) begin
                cipher_key = key2;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        chk("busy_cycles", 128'(n), 128'd10);
        chk("ready_low_while_busy", {127'h0, ready_early}, 128'h0);
        chk("ready_after", {127'h0, keys_ready}, 128'h1);
        chk("busy_after", {127'h0, busy}, 128'h0);
    endtask

    initial begin
        build_sbox();
        n_rst = 1'b0;
        start = 1'b0;
        cipher_key = '0;
        round_sel = 4'd0;
        #12;
        chk("reset_busy", {127'h0, busy}, 128'h0);
        chk("reset_ready", {127'h0, keys_ready}, 128'h0);
        chk("reset_round_key", round_key, 128'h0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        probe(4'd0, 128'h0);
        probe(4'd5, 128'h0);

        run_expand(KEY_A1, -1, 128'h0);
        probe(4'd1, A1_R1);
        probe(4'd2, A1_R2);
        probe(4'd10, A1_R10);
        probe(4'd0, KEY_A1);
        for (int s = 11; s < 16; s++) probe(4'(s), 128'h0);
        model_expand(KEY_A1);
        probe_all_model();

        run_expand(128'h0, -1, 128'h0);
        probe(4'd1, Z_R1);
        probe(4'd10, Z_R10);

        run_expand(KEY_A1, 3, {$urandom, $urandom, $urandom, $urandom});
        probe(4'd0, KEY_A1);
        probe(4'd10, A1_R10);

        cipher_key = KEY_A1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        round_sel = 4'd1;
        n_rst = 1'b0;
        #1;
        chk("abort_busy", {127'h0, busy}, 128'h0);
        chk("abort_ready", {127'h0, keys_ready}, 128'h0);
        chk("abort_round_key", round_key, 128'h0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        probe(4'd0, 128'h0);
        run_expand(KEY_A1, -1, 128'h0);
        probe(4'd1, A1_R1);
        probe(4'd10, A1_R10);

        run_expand(128'h0, -1, 128'h0);
        probe(4'd10, Z_R10);

        for (int r = 0; r < 3; r++) begin
            logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
            run_expand(k, -1, 128'h0);
            model_expand(k);
            probe_all_model();
        end

        for (int c = 0; c < 10 && sb_q.size() > 0; c++) tick();
        if (sb_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
